// File: rtl/uart_fifo_seq_ctrl.sv
// uart_fifo_seq_ctrl
// Sequences one 256x8 UART FIFO macro behind valid/ready streams. Pushes become
// active-low write strobes; reads are issued one at a time, the macro read
// latency is waited out and the byte lands in a holding register that the
// consumer sees as a valid/ready source.
// Build option: define UART_FIFO_THRESH_IRQ_EN to add the thresh input and a
// registered occupancy interrupt; without it thresh_irq is tied low.
module uart_fifo_seq_ctrl #(
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 2,
    parameter int THRESH   = 128,
    localparam int LW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [7:0]    m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [7:0]    fifo_wd,
    output logic          fifo_wrb,
    output logic          fifo_rdb,
    input  logic [7:0]    fifo_rdata,
    input  logic          fifo_empty,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          overrun,
    input  logic          clr_err,
`ifdef UART_FIFO_THRESH_IRQ_EN
    input  logic [LW-1:0] thresh,
`endif
    output logic          thresh_irq
);

    localparam logic [LW-1:0] LVL_ZERO  = {LW{1'b0}};
    localparam logic [LW-1:0] LVL_ONE   = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_DEPTH = LW'(DEPTH);
    // WAIT is held for READ_LAT cycles so the capture edge meets the data
    localparam logic [1:0]    WAIT_LOAD = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t        state_r;
    logic [1:0]    wait_cnt_r;
    logic          rdb_r;
    logic [LW-1:0] level_r;
    logic          full_r;
    logic          overrun_r;
    logic          m_valid_r;
    logic [7:0]    m_data_r;
    logic          thresh_irq_r;

    logic          push_s;
    logic          issue_s;
    logic          start_s;
    logic          capture_s;
    logic          pop_s;
    logic [LW-1:0] level_next_s;

    assign push_s    = s_valid & ~full_r;
    assign issue_s   = (state_r == ST_ISSUE);
    assign start_s   = (state_r == ST_IDLE) & (level_r != LVL_ZERO) & ~fifo_empty
                       & (~m_valid_r | m_ready);
    assign capture_s = (state_r == ST_WAIT) & (wait_cnt_r == 2'd0);
    assign pop_s     = m_valid_r & m_ready;

    assign s_ready    = ~full_r;
    assign fifo_wd    = s_data;
    assign fifo_wrb   = ~push_s;
    assign fifo_rdb   = rdb_r;
    assign level      = level_r;
    assign full       = full_r;
    assign overrun    = overrun_r;
    assign m_valid    = m_valid_r;
    assign m_data     = m_data_r;
    assign thresh_irq = thresh_irq_r;

    // Next occupancy: a push and a read issue in the same cycle cancel out
    always_comb begin
        level_next_s = level_r;
        if (push_s && !issue_s) begin
            level_next_s = level_r + LVL_ONE;
        end else if (!push_s && issue_s) begin
            level_next_s = level_r - LVL_ONE;
        end else begin
            level_next_s = level_r;
        end
    end

    // Occupancy counter with a registered full flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_r <= LVL_ZERO;
            full_r  <= 1'b0;
        end else begin
            level_r <= level_next_s;
            full_r  <= (level_next_s == LVL_DEPTH);
        end
    end

    // Read sequencer: one strobe per read, then wait out the macro latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 2'd0;
            rdb_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r <= ST_ISSUE;
                        rdb_r   <= 1'b0;
                    end else begin
                        rdb_r   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_r    <= ST_WAIT;
                    wait_cnt_r <= WAIT_LOAD;
                    rdb_r      <= 1'b1;
                end
                ST_WAIT: begin
                    rdb_r <= 1'b1;
                    if (wait_cnt_r == 2'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 2'd1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wait_cnt_r <= 2'd0;
                    rdb_r      <= 1'b1;
                end
            endcase
        end
    end

    // Holding register: a capture on the pop edge keeps m_valid high with new data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_r <= 1'b0;
            m_data_r  <= 8'h00;
        end else if (capture_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= fifo_rdata;
        end else if (pop_s) begin
            m_valid_r <= 1'b0;
        end
    end

    // Sticky overrun; a new overrun beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (s_valid && full_r) begin
            overrun_r <= 1'b1;
        end else if (clr_err) begin
            overrun_r <= 1'b0;
        end
    end

`ifdef UART_FIFO_THRESH_IRQ_EN
    localparam logic [LW-1:0] LVL_THRESH = LW'(THRESH);
    logic [LW-1:0] thresh_eff_s;

    assign thresh_eff_s = (thresh == LVL_ZERO) ? LVL_THRESH : thresh;

    // Registered occupancy threshold interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_irq_r <= 1'b0;
        end else begin
            thresh_irq_r <= (level_r >= thresh_eff_s);
        end
    end
`else
    assign thresh_irq_r = 1'b0;
`endif

endmodule
